// File: rtl/inv_chain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inv_chain_pkg
// Description : Shared FSM state encoding and default parameter values for
//               the inverting chain/ring pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package inv_chain_pkg;

  localparam int DEF_WIDTH  = 1;
  localparam int DEF_STAGES = 3;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_CHAIN = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RING  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/inv_chain_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : inv_stage
// Description : One WIDTH-bit registered inverter. A load request replaces
//               the stored word with a fixed pattern; otherwise the stage
//               captures ~d when enabled and holds when not.
// Revision    : 1.0 - initial release
// ============================================================================
module inv_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next stage value: load pattern wins over the inverting advance.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_val;
    end else if (en) begin
      data_d = ~d;
    end
  end

  // Stage register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule
`default_nettype wire

// File: rtl/inv_chain_pipe.sv
`default_nettype none
// ============================================================================
// Module      : inv_chain_pipe
// Description : STAGES-deep chain of registered inverters. In chain mode it
//               is a valid-qualified feed-forward pipeline; in ring mode the
//               last stage feeds the first and the loop free-runs. A DRAIN
//               state empties in-flight words before the loop closes. A
//               saturating counter tracks qualified output transitions.
// Revision    : 1.0 - initial release
// ============================================================================
module inv_chain_pipe
  import inv_chain_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             cnt_sat
);

  // Ring seed value of the last stage (pattern is 0,1,0,... from stage 0).
  localparam logic [WIDTH-1:0] LAST_LOAD = ((STAGES - 1) % 2 == 1) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  state_e            state_q, state_d;
  logic [STAGES-1:0] v_q, v_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              adv;
  logic              load;
  logic              ring_fb;
  logic [WIDTH-1:0]  out_nxt;

  logic [WIDTH-1:0]  s_q   [STAGES];
  logic [WIDTH-1:0]  s_src [STAGES];

  assign in_ready   = (state_q == ST_CHAIN);
  assign out_valid  = (state_q == ST_RING) | v_q[STAGES-1];
  assign out_data   = s_q[STAGES-1];
  assign toggle_cnt = cnt_q;
  assign cnt_sat    = &cnt_q;

  // Mode sequencing: decide per enabled cycle whether stages advance, get
  // seeded with the ring pattern, or hold (mode switches back to chain).
  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    adv     = 1'b0;
    load    = 1'b0;
    ring_fb = 1'b0;
    if (en) begin
      case (state_q)
        ST_CHAIN: begin
          if (mode && (v_q == '0)) begin
            state_d = ST_RING;
            load    = 1'b1;
            v_d     = '0;
          end else begin
            adv = 1'b1;
            v_d = {v_q[STAGES-2:0], in_valid & in_ready};
            if (mode) begin
              state_d = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!mode) begin
            // Back to chain with the pipeline frozen for this cycle.
            state_d = ST_CHAIN;
          end else if (v_q[STAGES-2:0] == '0) begin
            // Last valid word leaves the output as the ring is seeded.
            state_d = ST_RING;
            load    = 1'b1;
            v_d     = '0;
          end else begin
            adv = 1'b1;
            v_d = {v_q[STAGES-2:0], 1'b0};
          end
        end
        ST_RING: begin
          if (!mode) begin
            state_d = ST_CHAIN;
            v_d     = '0;
          end else begin
            adv     = 1'b1;
            ring_fb = 1'b1;
          end
        end
        default: begin
          state_d = ST_CHAIN;
          v_d     = '0;
        end
      endcase
    end
  end

  // Stage array: stage 0 takes the input word or, in ring, the last stage.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [WIDTH-1:0] LOAD_VAL = (k % 2 == 1) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    if (k == 0) begin : g_head
      assign s_src[k] = ring_fb ? s_q[STAGES-1] : in_data;
    end else begin : g_body
      assign s_src[k] = s_q[k-1];
    end
    inv_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (adv),
      .load    (load),
      .load_val(LOAD_VAL),
      .d       (s_src[k]),
      .q       (s_q[k])
    );
  end

  // Value the output stage will take at the coming edge.
  assign out_nxt = load ? LAST_LOAD : (adv ? ~s_q[STAGES-2] : s_q[STAGES-1]);

  // Toggle counter: clear dominates, saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (en && out_valid && (out_nxt != s_q[STAGES-1]) && !cnt_sat) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, valid and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CHAIN;
      v_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inv_chain_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_inv_chain_pipe
// Description : Self-checking bench for inv_chain_pipe: chain vectors with a
//               latency-aware scoreboard, drain into ring, ring sequence,
//               toggle counter, saturation, clear priority and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_chain_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       in_valid = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       d1 = 1'b0;
  logic [7:0] d8 = 8'h00;

  logic       o3_data, o3_valid, o3_rdy, o3_sat;
  logic [7:0] o3_cnt;
  logic [7:0] o4_data, o4_cnt;
  logic       o4_valid, o4_rdy, o4_sat;
  logic       os_data, os_valid, os_rdy, os_sat;
  logic [1:0] os_cnt;

  inv_chain_pipe #(.WIDTH(1), .STAGES(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_data(d1), .in_valid(in_valid),
    .in_ready(o3_rdy), .out_data(o3_data), .out_valid(o3_valid), .cnt_clr(cnt_clr),
    .toggle_cnt(o3_cnt), .cnt_sat(o3_sat));

  inv_chain_pipe #(.WIDTH(8), .STAGES(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_data(d8), .in_valid(in_valid),
    .in_ready(o4_rdy), .out_data(o4_data), .out_valid(o4_valid), .cnt_clr(cnt_clr),
    .toggle_cnt(o4_cnt), .cnt_sat(o4_sat));

  inv_chain_pipe #(.WIDTH(1), .STAGES(3), .CNT_W(2)) dut3s (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_data(d1), .in_valid(in_valid),
    .in_ready(os_rdy), .out_data(os_data), .out_valid(os_valid), .cnt_clr(cnt_clr),
    .toggle_cnt(os_cnt), .cnt_sat(os_sat));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         due;
  } sb_t;

  typedef struct {
    bit         en;
    bit         vld;
    bit         d1;
    logic [7:0] d8;
    bit         e1;
    logic [7:0] e8;
  } vec_t;

  sb_t  q3[$];
  sb_t  q4[$];
  vec_t tbl[10];
  bit   sb3_on = 1'b0;
  bit   sb4_on = 1'b0;
  bit   ring3 = 1'b0;
  int   ring_steps = 0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  logic hold_v;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Ring model of the 3-stage instances: output flips every 3 steps.
  function automatic logic exp3();
    return ((ring_steps / 3) % 2) == 1;
  endfunction

  task automatic sb_pop(input string nm, inout sb_t q[$], input logic [7:0] act);
    sb_t e;
    if (q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s_unexpected: got output %0h expected none", nm, act);
    end else begin
      e = q.pop_front();
      chk({nm, "_data"}, {24'h0, act}, {24'h0, e.data});
      chk({nm, "_lat"}, cyc, e.due);
    end
  endtask

  task automatic tick();
    bit en_s;
    en_s = en;
    @(posedge clk);
    #1;
    if (en_s) cyc++;
    if (en_s && ring3) ring_steps++;
    if (en_s && sb3_on && o3_valid) sb_pop("sb3", q3, {7'h0, o3_data});
    if (en_s && sb4_on && o4_valid) sb_pop("sb4", q4, o4_data);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 8'h5A, 1'b1, 8'h5A};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, 8'hC3};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 8'hFF};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 8'h77, 1'b1, 8'h77};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 8'h81, 1'b1, 8'h81};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 8'h3C};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 8'hA5};

    // Reset values
    #12;
    chk("rst_out3", {30'h0, o3_valid, o3_data}, 32'h0);
    chk("rst_rdy", {29'h0, o3_rdy, o4_rdy, os_rdy}, 32'h7);
    chk("rst_cnt", {24'h0, o3_cnt}, 32'h0);
    chk("rst_sat", {29'h0, o3_sat, o4_sat, os_sat}, 32'h0);
    chk("rst_out4", {23'h0, o4_valid, o4_data}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Chain vectors through both pipeline depths
    mode = 1'b0;
    sb3_on = 1'b1;
    sb4_on = 1'b1;
    for (int i = 0; i < 10; i++) begin
      en = tbl[i].en;
      in_valid = tbl[i].vld;
      d1 = tbl[i].d1;
      d8 = tbl[i].d8;
      if (tbl[i].en && tbl[i].vld) begin
        q3.push_back('{{7'h0, tbl[i].e1}, cyc + 3});
        q4.push_back('{tbl[i].e8, cyc + 4});
      end
      tick();
    end
    en = 1'b1;
    in_valid = 1'b0;
    repeat (5) tick();
    chk("chain_sb_empty", q3.size() + q4.size(), 0);
    chk("chain_in_ready", {31'h0, o3_rdy}, 32'h1);

    // Two words in flight, then switch to ring: drain first
    in_valid = 1'b1; d1 = 1'b0; d8 = 8'h11;
    q3.push_back('{8'h01, cyc + 3});
    q4.push_back('{8'h11, cyc + 4});
    tick();
    d1 = 1'b1; d8 = 8'h22;
    q3.push_back('{8'h00, cyc + 3});
    q4.push_back('{8'h22, cyc + 4});
    tick();
    mode = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("drain_in_ready", {30'h0, o3_rdy, o4_rdy}, 32'h0);
    in_valid = 1'b1; d1 = 1'b0; d8 = 8'hEE;
    tick();
    sb3_on = 1'b0;
    tick();
    ring3 = 1'b1;
    ring_steps = 0;
    sb4_on = 1'b0;
    in_valid = 1'b0;
    chk("drain_sb_empty", q3.size() + q4.size(), 0);

    // Ring output sequence 0,0,0,1,1,1,0 for three stages
    for (int i = 0; i < 7; i++) begin
      chk("ring_seq", {31'h0, o3_data}, {31'h0, exp3()});
      chk("ring_seq_twin", {30'h0, os_valid, os_data}, {30'h0, 1'b1, exp3()});
      chk("ring_valid", {31'h0, o3_valid}, 32'h1);
      tick();
    end
    chk("ring_even_const", {23'h0, o4_valid, o4_data}, {23'h0, 1'b1, 8'hFF});

    // Counter: 12 enabled cycles after clear, then hold with en low
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cnt_clr", {24'h0, o3_cnt}, 32'h0);
    repeat (12) tick();
    chk("cnt_12", {24'h0, o3_cnt}, 32'd4);
    chk("cnt_even", {24'h0, o4_cnt}, 32'd0);
    en = 1'b0;
    repeat (5) tick();
    chk("cnt_hold", {24'h0, o3_cnt}, 32'd4);
    chk("data_hold", {31'h0, o3_data}, {31'h0, exp3()});
    en = 1'b1;

    // Saturation of the narrow counter
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    repeat (15) tick();
    chk("sat_cnt", {30'h0, os_cnt}, 32'd3);
    chk("sat_flag", {31'h0, os_sat}, 32'h1);
    chk("wide_cnt", {23'h0, o3_sat, o3_cnt}, 32'd5);

    // Clear on the same edge as an output toggle
    for (int i = 0; i < 3; i++) begin
      if (((ring_steps + 1) % 3) == 0) break;
      tick();
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_prio", {29'h0, os_sat, os_cnt}, 32'h0);
    chk("clr_prio_wide", {24'h0, o3_cnt}, 32'h0);
    chk("clr_edge_data", {31'h0, o3_data}, {31'h0, exp3()});
    repeat (3) tick();
    chk("cnt_after_clr", {24'h0, o3_cnt}, 32'd1);
    en = 1'b0;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_no_en", {24'h0, o3_cnt}, 32'h0);

    // Ring back to chain: valids cleared, data left in place
    en = 1'b1;
    mode = 1'b0;
    ring3 = 1'b0;
    hold_v = exp3();
    tick();
    chk("r2c_ready_valid", {30'h0, o3_rdy, o3_valid}, 32'h2);
    chk("r2c_data", {31'h0, o3_data}, {31'h0, hold_v});

    // Re-enter ring from an empty chain, then reset asynchronously
    mode = 1'b1;
    tick();
    ring3 = 1'b1;
    ring_steps = 0;
    chk("reentry_seed", {30'h0, o3_valid, o3_data}, {30'h0, 1'b1, exp3()});
    repeat (4) tick();
    chk("pre_rst_data", {31'h0, o3_data}, {31'h0, exp3()});
    chk("pre_rst_cnt", {24'h0, o3_cnt}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out3", {30'h0, o3_valid, o3_data}, 32'h0);
    chk("arst_rdy", {29'h0, o3_rdy, o4_rdy, os_rdy}, 32'h7);
    chk("arst_cnt", {24'h0, o3_cnt}, 32'h0);
    chk("arst_sat", {29'h0, o3_sat, o4_sat, os_sat}, 32'h0);
    chk("arst_out4", {15'h0, o4_valid, o4_data, o4_cnt}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
